lsu_bus_arbiter: RTL and testbench
==================================

// Module: lsu_bus_arbiter
// PURPOSE
//  Two-master arbiter in front of the load/store unit (LSU) address/data bus.
//  Master 0 is the CPU data port; master 1 is the debug/program loader port.
//  Selects one request per cycle (round-robin) and drives the single LSU port.
//  Returns each read result only to the master that issued it, after a fixed LSU latency.
// PARAMETERS
//  ADDR_W    32  address width (LSU decodes addr[31:12] for memory and I/O)
//  DATA_W    32  store/load data width
//  MASK_W    4   byte-mask width (DATA_W/8)
//  RSP_LAT   1   LSU read latency in cycles (0..3); i_lsu_ldData is valid RSP_LAT cycles after the address
//  LOCK_MAX  8   maximum consecutive locked beats (used only with LSU_ARB_LOCK_EN)
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_reset        in   1       reset, asynchronous, active-low
//  i_mN_req       in   1       master N (N=0,1) request valid
//  i_mN_wren      in   1       master N: 1 = store, 0 = load
//  i_mN_addr      in   ADDR_W  master N byte address
//  i_mN_wdata     in   DATA_W  master N store data
//  i_mN_mask      in   MASK_W  master N byte mask
//  i_mN_lock      in   1       master N lock request (ignored without LSU_ARB_LOCK_EN)
//  o_mN_gnt       out  1       master N request accepted this cycle
//  o_mN_rvalid    out  1       master N load data valid, one-cycle pulse
//  o_mN_rdata     out  DATA_W  master N load data, registered
//  o_lsu_wren     out  1       to LSU: write enable
//  o_lsu_addr     out  ADDR_W  to LSU: address
//  o_lsu_stData   out  DATA_W  to LSU: store data
//  o_lsu_mask     out  MASK_W  to LSU: byte mask
//  i_lsu_ldData   in   DATA_W  from LSU: load data
// BEHAVIOUR
//  - Reset (i_reset=0, async): all o_*rvalid=0, all o_*rdata=0, response pipe cleared, rr_last=1 (M0 wins the first tie), FSM=ARB, lock counter=0.
//  - Grant is combinational in the same cycle: o_mN_gnt = i_mN_req & selected. At most one gnt per cycle.
//  - Arbitration with both requests in ARB: grant the master not equal to rr_last; rr_last <= granted id.
//  - Arbitration with one request: grant that master; rr_last updates.
//  - LSU port: while a gnt is high, all o_lsu_* mirror the granted master's inputs.
//  - LSU port with no gnt: o_lsu_wren=0, addr/stData/mask=0. No store is ever issued without a gnt.
//  - Load accepted in cycle t: {valid, id} enters a RSP_LAT-deep pipe.
//    i_lsu_ldData is sampled at the end of cycle t+RSP_LAT into o_m<id>_rdata.
//    o_m<id>_rvalid=1 for exactly cycle t+RSP_LAT+1.
//  - Stores produce no rvalid. Back-to-back loads give back-to-back rvalids, in order.
//  - o_mN_rdata holds its value until the next response to master N. The other master's rdata is never disturbed.
//  - RSP_LAT=0: data is sampled in the grant cycle; rvalid follows at t+1.
//  - Request dropped without gnt: no side effect. Masters must hold req, addr and data until gnt.
//  - Reset asserted mid-operation: in-flight loads are discarded; no rvalid after reset release for pre-reset loads.
// CONFIGURATION
//  LSU_ARB_LOCK_EN defined:
//   - FSM states ARB -> LOCK0/LOCK1. Entered when the granted master has lock=1.
//   - In LOCKn only master n is granted. Lock counter increments per granted beat.
//   - Return to ARB when lock=0, req=0, or the counter reaches LOCK_MAX. On a LOCK_MAX exit, the other master wins the next tie.
//  LSU_ARB_LOCK_EN undefined:
//   - i_mN_lock is ignored; the FSM is permanently ARB; no lock counter is synthesized.
// STRUCTURE
//  Package lsu_arb_pkg:
//   - typedef lsu_req_t struct {wren, addr, wdata, mask}
//   - typedef arb_state_e {ARB, LOCK0, LOCK1}
//   - localparam MASTER_ID_W = 1
//  Sub-module lsu_arb_rsp_pipe:
//   - RSP_LAT-deep shift register of {valid, id} with async active-low clear.
//   - Outputs the capture strobe and id.
// TESTING
//  - Reset: hold i_reset=0 with random inputs -> all rvalid=0, rdata=0, lsu_wren=0.
//  - Both masters request loads, 4 cycles -> gnt order M0,M1,M0,M1. Each rvalid arrives RSP_LAT+1 cycles after its gnt, with the correct rdata.
//  - M1 stores 0xDEADBEEF mask 4'b0011 to 0x1000_0000 while M0 idle -> one cycle lsu_wren=1 with exact addr/data/mask, no rvalid.
//  - M0 load at t, reset pulse at t+1 -> no m0_rvalid after reset release, m0_rdata=0.
//  - LSU_ARB_LOCK_EN: M0 lock=1 for 10 beats while M1 requests -> M0 gets 8 gnts, then M1 gnt, then M0.
//  - Without LSU_ARB_LOCK_EN, same stimulus -> strict alternation of grants.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types and helpers for the LSU bus arbiter.
// Request bundle, FSM states and the round-robin pick function.
package lsu_arb_pkg;

    localparam int MASTER_ID_W = 1;
    localparam int LSU_ADDR_W  = 32;
    localparam int LSU_DATA_W  = 32;
    localparam int LSU_MASK_W  = 4;

    typedef struct packed {
        logic                  wren;
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic [LSU_MASK_W-1:0] mask;
    } lsu_req_t;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    // One-hot pick; on a tie the master that did not win last time goes.
    function automatic logic [1:0] rr_pick(
        input logic [1:0] req,
        input logic       last
    );
        logic [1:0] g;
        g = 2'b00;
        unique case (1'b1)
            (req == 2'b11): g = last ? 2'b01 : 2'b10;
            (req == 2'b01): g = 2'b01;
            (req == 2'b10): g = 2'b10;
            default:        g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/lsu_arb_rsp_pipe.sv
// lsu_arb_rsp_pipe: RSP_LAT-deep {valid, id} delay line for loads.
// Its output marks the cycle in which the LSU load data is captured.
module lsu_arb_rsp_pipe
    import lsu_arb_pkg::*;
#(
    parameter int RSP_LAT = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [MASTER_ID_W-1:0] i_id,
    output logic                   o_cap,
    output logic [MASTER_ID_W-1:0] o_cap_id
);

    generate
        if (RSP_LAT == 0) begin : g_bypass
            assign o_cap    = i_valid;
            assign o_cap_id = i_id;
        end else begin : g_shift
            logic [RSP_LAT-1:0]     vld_q;
            logic [MASTER_ID_W-1:0] id_q [RSP_LAT];

            // Shift the load tag one stage per cycle; reset drops in-flight loads.
            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    vld_q <= '0;
                    for (int i = 0; i < RSP_LAT; i++) begin
                        id_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= i_valid;
                    id_q[0]  <= i_id;
                    for (int i = 1; i < RSP_LAT; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        id_q[i]  <= id_q[i-1];
                    end
                end
            end

            assign o_cap    = vld_q[RSP_LAT-1];
            assign o_cap_id = id_q[RSP_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/lsu_bus_arbiter.sv
// lsu_bus_arbiter: round-robin two-master arbiter in front of the LSU bus.
// Optional bus locking is built only when LSU_ARB_LOCK_EN is defined.
module lsu_bus_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MASK_W   = 4,
    parameter int RSP_LAT  = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_req,
    input  logic              i_m0_wren,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    input  logic [MASK_W-1:0] i_m0_mask,
    input  logic              i_m0_lock,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_wren,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    input  logic [MASK_W-1:0] i_m1_mask,
    input  logic              i_m1_lock,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_lsu_wren,
    output logic [ADDR_W-1:0] o_lsu_addr,
    output logic [DATA_W-1:0] o_lsu_stData,
    output logic [MASK_W-1:0] o_lsu_mask,
    input  logic [DATA_W-1:0] i_lsu_ldData
);

    logic [1:0]             req;
    logic [1:0]             pick;
    logic [1:0]             gnt;
    logic                   rr_last_q;
    lsu_req_t               m0_bus;
    lsu_req_t               m1_bus;
    lsu_req_t               lsu_bus;
    logic                   ld_acc;
    logic [MASTER_ID_W-1:0] ld_id;
    logic                   cap;
    logic [MASTER_ID_W-1:0] cap_id;

    assign req = {i_m1_req, i_m0_req};

    assign m0_bus = '{
        wren:  i_m0_wren,
        addr:  i_m0_addr,
        wdata: i_m0_wdata,
        mask:  i_m0_mask
    };

    assign m1_bus = '{
        wren:  i_m1_wren,
        addr:  i_m1_addr,
        wdata: i_m1_wdata,
        mask:  i_m1_mask
    };

`ifdef LSU_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    arb_state_e       state_q;
    logic [CNT_W-1:0] lock_cnt_q;

    // The locked master owns the bus; otherwise fall back to round-robin.
    always_comb begin
        pick = 2'b00;
        unique case (state_q)
            LOCK0:   pick = 2'b01;
            LOCK1:   pick = 2'b10;
            default: pick = rr_pick(req, rr_last_q);
        endcase
    end

    // Lock FSM: enter on a locked grant, leave on release or beat limit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            unique case (state_q)
                LOCK0: begin
                    if (!i_m0_req || !i_m0_lock ||
                        lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                        state_q    <= ARB;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                LOCK1: begin
                    if (!i_m1_req || !i_m1_lock ||
                        lock_cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                        state_q    <= ARB;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (gnt[0] && i_m0_lock && LOCK_MAX > 1) begin
                        state_q    <= LOCK0;
                        lock_cnt_q <= CNT_W'(1);
                    end else if (gnt[1] && i_m1_lock && LOCK_MAX > 1) begin
                        state_q    <= LOCK1;
                        lock_cnt_q <= CNT_W'(1);
                    end
                end
            endcase
        end
    end
`else
    logic unused_lock;

    assign unused_lock = i_m0_lock ^ i_m1_lock ^ (LOCK_MAX > 0);
    assign pick        = rr_pick(req, rr_last_q);
`endif

    // No grants while reset is held, so nothing reaches the LSU.
    assign gnt      = pick & req & {2{i_reset}};
    assign o_m0_gnt = gnt[0];
    assign o_m1_gnt = gnt[1];

    // Remember the last winner so the other master wins the next tie.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rr_last_q <= 1'b1;
        end else if (|gnt) begin
            rr_last_q <= gnt[1];
        end
    end

    // Steer the granted master onto the LSU port, idle bus otherwise.
    always_comb begin
        lsu_bus = '0;
        unique case (1'b1)
            gnt[0]:  lsu_bus = m0_bus;
            gnt[1]:  lsu_bus = m1_bus;
            default: lsu_bus = '0;
        endcase
    end

    assign o_lsu_wren   = lsu_bus.wren;
    assign o_lsu_addr   = lsu_bus.addr;
    assign o_lsu_stData = lsu_bus.wdata;
    assign o_lsu_mask   = lsu_bus.mask;

    assign ld_acc = (gnt[0] & ~i_m0_wren) | (gnt[1] & ~i_m1_wren);
    assign ld_id  = MASTER_ID_W'(gnt[1]);

    lsu_arb_rsp_pipe #(
        .RSP_LAT (RSP_LAT)
    ) u_rsp_pipe (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (ld_acc),
        .i_id     (ld_id),
        .o_cap    (cap),
        .o_cap_id (cap_id)
    );

    // Capture load data for its owner and pulse that owner's rvalid.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
        end else begin
            o_m0_rvalid <= cap && (cap_id == MASTER_ID_W'(0));
            o_m1_rvalid <= cap && (cap_id == MASTER_ID_W'(1));
            if (cap && (cap_id == MASTER_ID_W'(0))) begin
                o_m0_rdata <= i_lsu_ldData;
            end
            if (cap && (cap_id == MASTER_ID_W'(1))) begin
                o_m1_rdata <= i_lsu_ldData;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus_arbiter.sv
// tb_lsu_bus_arbiter: directed and random checks of lsu_bus_arbiter.
// Expected values come from a cycle-level model of the arbitration rules.
module tb_lsu_bus_arbiter;

    localparam int RSP_LAT  = 1;
    localparam int LOCK_MAX = 8;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        mreq  [2];
    logic        mwren [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [3:0]  mmask [2];
    logic        mlock [2];
    logic [31:0] i_lsu_ldData;

    logic        o_m0_gnt, o_m1_gnt;
    logic        o_m0_rvalid, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic        o_lsu_wren;
    logic [31:0] o_lsu_addr, o_lsu_stData;
    logic [3:0]  o_lsu_mask;

    lsu_bus_arbiter #(
        .RSP_LAT  (RSP_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_m0_req     (mreq[0]),
        .i_m0_wren    (mwren[0]),
        .i_m0_addr    (maddr[0]),
        .i_m0_wdata   (mwd[0]),
        .i_m0_mask    (mmask[0]),
        .i_m0_lock    (mlock[0]),
        .o_m0_gnt     (o_m0_gnt),
        .o_m0_rvalid  (o_m0_rvalid),
        .o_m0_rdata   (o_m0_rdata),
        .i_m1_req     (mreq[1]),
        .i_m1_wren    (mwren[1]),
        .i_m1_addr    (maddr[1]),
        .i_m1_wdata   (mwd[1]),
        .i_m1_mask    (mmask[1]),
        .i_m1_lock    (mlock[1]),
        .o_m1_gnt     (o_m1_gnt),
        .o_m1_rvalid  (o_m1_rvalid),
        .o_m1_rdata   (o_m1_rdata),
        .o_lsu_wren   (o_lsu_wren),
        .o_lsu_addr   (o_lsu_addr),
        .o_lsu_stData (o_lsu_stData),
        .o_lsu_mask   (o_lsu_mask),
        .i_lsu_ldData (i_lsu_ldData)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int due;
        int id;
    } rsp_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    rsp_t        pend [$];
    logic [31:0] ldlog [int];
    logic [31:0] exp_rd [2];
    int          rr_last = 1;
    int          lk = -1;
    int          lkcnt = 0;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int n, input logic req, input logic wren,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] mask, input logic lock);
        mreq[n]  = req;
        mwren[n] = wren;
        maddr[n] = addr;
        mwd[n]   = wd;
        mmask[n] = mask;
        mlock[n] = lock;
    endtask

    task automatic drv_rand(input int n, input logic wren, input logic lock);
        drv(n, 1'b1, wren, $urandom(), $urandom(), 4'($urandom()), lock);
    endtask

    // One cycle: check DUT against the model, then advance both.
    task automatic step(output bit g0, output bit g1,
                        output bit d0, output bit d1);
        bit          rv [2];
        logic [68:0] exp_lsu;
        i_lsu_ldData = $urandom();
        #1;
        if (!i_reset) begin
            pend.delete();
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            rr_last   = 1;
            lk        = -1;
            lkcnt     = 0;
        end
        g0 = 0;
        g1 = 0;
        if (i_reset) begin
            if (lk == 0) g0 = mreq[0];
            else if (lk == 1) g1 = mreq[1];
            else if (mreq[0] && mreq[1]) begin
                g0 = (rr_last == 1);
                g1 = !g0;
            end else begin
                g0 = mreq[0];
                g1 = mreq[1];
            end
        end
        d0 = o_m0_gnt;
        d1 = o_m1_gnt;
        chk("gnt0", 96'(o_m0_gnt), 96'(g0));
        chk("gnt1", 96'(o_m1_gnt), 96'(g1));
        exp_lsu = '0;
        if (g0) exp_lsu = {mwren[0], maddr[0], mwd[0], mmask[0]};
        if (g1) exp_lsu = {mwren[1], maddr[1], mwd[1], mmask[1]};
        chk("lsu_port",
            96'({o_lsu_wren, o_lsu_addr, o_lsu_stData, o_lsu_mask}),
            96'(exp_lsu));
        rv[0] = 0;
        rv[1] = 0;
        foreach (pend[k]) begin
            if (pend[k].due == cyc) begin
                rv[pend[k].id]     = 1;
                exp_rd[pend[k].id] = ldlog[cyc-1];
            end
        end
        for (int k = pend.size() - 1; k >= 0; k--) begin
            if (pend[k].due <= cyc) pend.delete(k);
        end
        chk("rvalid0", 96'(o_m0_rvalid), 96'(rv[0]));
        chk("rvalid1", 96'(o_m1_rvalid), 96'(rv[1]));
        chk("rdata0", 96'(o_m0_rdata), 96'(exp_rd[0]));
        chk("rdata1", 96'(o_m1_rdata), 96'(exp_rd[1]));
        if (g0 && !mwren[0]) pend.push_back('{cyc + RSP_LAT + 1, 0});
        if (g1 && !mwren[1]) pend.push_back('{cyc + RSP_LAT + 1, 1});
        if (g0 || g1) rr_last = g1 ? 1 : 0;
`ifdef LSU_ARB_LOCK_EN
        if (i_reset) begin
            if (lk < 0) begin
                if (LOCK_MAX > 1 && ((g0 && mlock[0]) || (g1 && mlock[1]))) begin
                    lk    = g1 ? 1 : 0;
                    lkcnt = 1;
                end
            end else if (!mreq[lk] || !mlock[lk]) begin
                lk = -1;
            end else begin
                lkcnt++;
                if (lkcnt == LOCK_MAX) lk = -1;
            end
        end
`endif
        ldlog[cyc] = i_lsu_ldData;
        @(posedge i_clk);
        cyc++;
        @(negedge i_clk);
    endtask

    initial begin
        bit g0, g1, d0, d1;
        int m0beats;
        int seq [$];
        int exp_seq [11];

        for (int n = 0; n < 2; n++) drv(n, 0, 0, '0, '0, '0, 0);
        i_lsu_ldData = '0;
        @(negedge i_clk);

        // Reset held with random traffic on both masters.
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_rand(0, 1'($urandom()), 1'($urandom()));
            drv_rand(1, 1'($urandom()), 1'($urandom()));
            step(g0, g1, d0, d1);
            chk("rst_wren", 96'(o_lsu_wren), 96'(0));
            chk("rst_rdata0", 96'(o_m0_rdata), 96'(0));
        end
        i_reset = 1'b1;

        // Both masters issue loads: grants alternate starting with M0.
        drv_rand(0, 0, 0);
        drv_rand(1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(g0, g1, d0, d1);
            chk("alt_order", 96'({d0, d1}), (i % 2 == 0) ? 96'(2'b10) : 96'(2'b01));
            if (d0) drv_rand(0, 0, 0);
            if (d1) drv_rand(1, 0, 0);
        end
        mreq[0] = 0;
        mreq[1] = 0;
        for (int i = 0; i < RSP_LAT + 2; i++) step(g0, g1, d0, d1);

        // Single store from M1 with M0 idle.
        drv(1, 1, 1, 32'h1000_0000, 32'hDEAD_BEEF, 4'b0011, 0);
        #1;
        chk("st_port", 96'({o_lsu_wren, o_lsu_addr, o_lsu_stData, o_lsu_mask}),
            96'({1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'b0011}));
        step(g0, g1, d0, d1);
        mreq[1] = 0;
        for (int i = 0; i < RSP_LAT + 2; i++) begin
            step(g0, g1, d0, d1);
            chk("st_no_rvalid", 96'({o_m0_rvalid, o_m1_rvalid, o_lsu_wren}), 96'(0));
        end

        // M0 load, then reset in the following cycle drops the response.
        drv_rand(0, 0, 0);
        step(g0, g1, d0, d1);
        mreq[0] = 0;
        i_reset = 1'b0;
        step(g0, g1, d0, d1);
        i_reset = 1'b1;
        for (int i = 0; i < RSP_LAT + 3; i++) begin
            step(g0, g1, d0, d1);
            chk("rst_drop_rv", 96'(o_m0_rvalid), 96'(0));
        end
        chk("rst_drop_rd", 96'(o_m0_rdata), 96'(0));

        // M0 wants 10 locked beats while M1 keeps requesting.
        i_reset = 1'b0;
        step(g0, g1, d0, d1);
        i_reset = 1'b1;
`ifdef LSU_ARB_LOCK_EN
        exp_seq = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
        m0beats = 0;
        drv_rand(0, 1, 1);
        drv_rand(1, 1, 0);
        for (int c = 0; c < 40 && m0beats < 10; c++) begin
            step(g0, g1, d0, d1);
            if (d0) begin
                m0beats++;
                seq.push_back(0);
                if (m0beats < 10) drv_rand(0, 1, 1);
                else mreq[0] = 0;
            end
            if (d1) begin
                seq.push_back(1);
                drv_rand(1, 1, 0);
            end
        end
        chk("lock_beats", 96'(m0beats), 96'(10));
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("lock_seq%0d", i),
                96'((i < seq.size()) ? seq[i] : 9), 96'(exp_seq[i]));
        end
        mreq[0] = 0;
        mreq[1] = 0;
        step(g0, g1, d0, d1);

        // Random traffic with held requests and occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!mreq[n] && $urandom_range(1, 0) == 1) begin
                    drv_rand(n, 1'($urandom()), 1'($urandom()));
                end
                mlock[n] = 1'($urandom());
            end
            i_reset = ($urandom_range(60, 0) == 0) ? 1'b0 : 1'b1;
            step(g0, g1, d0, d1);
            if (g0) mreq[0] = 0;
            if (g1) mreq[1] = 0;
        end
        i_reset = 1'b1;
        mreq[0] = 0;
        mreq[1] = 0;
        for (int i = 0; i < RSP_LAT + 3; i++) step(g0, g1, d0, d1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
